// File: rtl/dmem_rv32.sv
// RV32 data memory: byte/half/word loads and stores with one-cycle registered response.
// Misaligned, out-of-range and illegal-funct3 requests fault without touching memory.
module dmem_rv32 #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    localparam logic [2:0] F3B  = 3'b000;
    localparam logic [2:0] F3H  = 3'b001;
    localparam logic [2:0] F3W  = 3'b010;
    localparam logic [2:0] F3BU = 3'b100;
    localparam logic [2:0] F3HU = 3'b101;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic [31:0]   offset;
    logic [AW-1:0] word_idx;
    logic          in_range;
    logic          illegal;
    logic          misaligned;
    logic          fault;
    logic [3:0]    byte_en;
    logic [31:0]   wdata_lanes;

    logic        resp_valid_q;
    logic        fault_q;
    logic        load_q;
    logic [31:0] rword_q;
    logic [1:0]  lane_q;
    logic [2:0]  funct3_q;

    assign req_ready = !rst;
    assign accept    = req_valid && req_ready;
    // Modular subtraction makes addresses below the base wrap high and fall out of range.
    assign offset    = req_addr - BASE_ADDR;
    assign word_idx  = offset[AW+1:2];
    assign in_range  = (offset[31:AW+2] == '0);

    always_comb begin
        illegal     = 1'b0;
        misaligned  = 1'b0;
        byte_en     = 4'b0000;
        wdata_lanes = req_wdata;
        case (req_funct3)
            F3B: begin
                byte_en     = 4'b0001 << offset[1:0];
                wdata_lanes = {4{req_wdata[7:0]}};
            end
            F3H: begin
                misaligned  = offset[0];
                byte_en     = offset[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{req_wdata[15:0]}};
            end
            F3W: begin
                misaligned = (offset[1:0] != 2'b00);
                byte_en    = 4'b1111;
            end
            F3BU:    illegal = req_we;
            F3HU: begin
                illegal    = req_we;
                misaligned = offset[0];
            end
            default: illegal = 1'b1;
        endcase
        fault = illegal || misaligned || !in_range;
    end

    always_ff @(posedge clk) begin
        if (accept && !fault) begin
            if (req_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (byte_en[b]) begin
                        mem[word_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
                    end
                end
            end else begin
                rword_q  <= mem[word_idx];
                lane_q   <= offset[1:0];
                funct3_q <= req_funct3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            load_q       <= 1'b0;
        end else begin
            resp_valid_q <= accept;
            fault_q      <= accept && fault;
            load_q       <= accept && !req_we && !fault;
        end
    end

    always_comb begin
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        byte_sel   = rword_q[8*lane_q +: 8];
        half_sel   = lane_q[1] ? rword_q[31:16] : rword_q[15:0];
        resp_rdata = '0;
        if (resp_valid_q && load_q) begin
            case (funct3_q)
                F3B:     resp_rdata = {{24{byte_sel[7]}}, byte_sel};
                F3BU:    resp_rdata = {24'b0, byte_sel};
                F3H:     resp_rdata = {{16{half_sel[15]}}, half_sel};
                F3HU:    resp_rdata = {16'b0, half_sel};
                default: resp_rdata = rword_q;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_fault = fault_q;

endmodule

// File: tb/tb_dmem_rv32.sv
// Directed bench for dmem_rv32: back-to-back vector table plus reset corner sequences.
module tb_dmem_rv32;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_2000;

    localparam logic [2:0] B  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] W  = 3'b010;
    localparam logic [2:0] BU = 3'b100;
    localparam logic [2:0] HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] off;
        logic [31:0] wd;
        logic        fault;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[$];

    dmem_rv32 #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_fault(resp_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] off, input logic [31:0] wd,
                       input logic fault, input logic [31:0] rd);
        vec_t v;
        v.name = name; v.we = we; v.f3 = f3; v.off = off; v.wd = wd;
        v.fault = fault; v.rd = rd;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] off,
                         input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = BASE + off;
        req_wdata  = wd;
    endtask

    task automatic single(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] off, input logic [31:0] wd,
                          input logic fault, input logic [31:0] rd);
        drive(we, f3, off, wd);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check({name, " valid"}, {31'b0, resp_valid}, 32'd1);
        check({name, " fault"}, {31'b0, resp_fault}, {31'b0, fault});
        check({name, " rdata"}, resp_rdata, rd);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = W;
        req_addr = '0; req_wdata = '0;

        add("sw deadbeef",  1, W,  32'h10, 32'hDEAD_BEEF, 0, 32'h0);
        add("lw 0x10",      0, W,  32'h10, 32'h0,         0, 32'hDEAD_BEEF);
        add("sb 0x80",      1, B,  32'h13, 32'h1234_5680, 0, 32'h0);
        add("lb 0x13",      0, B,  32'h13, 32'h0,         0, 32'hFFFF_FF80);
        add("lbu 0x13",     0, BU, 32'h13, 32'h0,         0, 32'h0000_0080);
        add("lw after sb",  0, W,  32'h10, 32'h0,         0, 32'h80AD_BEEF);
        add("sw 0x20",      1, W,  32'h20, 32'h1122_3344, 0, 32'h0);
        add("sh 0x22",      1, H,  32'h22, 32'hABCD_1234, 0, 32'h0);
        add("lw after sh",  0, W,  32'h20, 32'h0,         0, 32'h1234_3344);
        add("lh misalign",  0, H,  32'h21, 32'h0,         1, 32'h0);
        add("lh 0x22",      0, H,  32'h22, 32'h0,         0, 32'h0000_1234);
        add("lhu 0x20",     0, HU, 32'h20, 32'h0,         0, 32'h0000_3344);
        add("sh 0x20",      1, H,  32'h20, 32'h0000_8001, 0, 32'h0);
        add("lh neg",       0, H,  32'h20, 32'h0,         0, 32'hFFFF_8001);
        add("lhu neg",      0, HU, 32'h20, 32'h0,         0, 32'h0000_8001);
        add("lb lane1",     0, B,  32'h21, 32'h0,         0, 32'hFFFF_FF80);
        add("lbu lane2",    0, BU, 32'h22, 32'h0,         0, 32'h0000_0034);
        add("sw word0",     1, W,  32'h00, 32'h5555_5555, 0, 32'h0);
        add("sw top",       1, W,  DEPTH*4-4, 32'hCAFE_F00D, 0, 32'h0);
        add("lw oor",       0, W,  DEPTH*4, 32'h0,        1, 32'h0);
        add("sw oor",       1, W,  DEPTH*4, 32'h0000_0BAD, 1, 32'h0);
        add("sw below",     1, W,  32'hFFFF_FFFC, 32'h0BAD_0BAD, 1, 32'h0);
        add("lw top",       0, W,  DEPTH*4-4, 32'h0,      0, 32'hCAFE_F00D);
        add("lw word0",     0, W,  32'h00, 32'h0,         0, 32'h5555_5555);
        add("ld f3=011",    0, 3'b011, 32'h10, 32'h0,     1, 32'h0);
        add("ld f3=110",    0, 3'b110, 32'h10, 32'h0,     1, 32'h0);
        add("st f3=111",    1, 3'b111, 32'h10, 32'h0,     1, 32'h0);
        add("st as bu",     1, BU, 32'h10, 32'h0,         1, 32'h0);
        add("st as hu",     1, HU, 32'h10, 32'h0,         1, 32'h0);
        add("sw misalign",  1, W,  32'h12, 32'h0,         1, 32'h0);
        add("lw misalign",  0, W,  32'h11, 32'h0,         1, 32'h0);
        add("lw unchanged", 0, W,  32'h10, 32'h0,         0, 32'h80AD_BEEF);
        add("b2b sw A",     1, W,  32'h40, 32'h0102_0304, 0, 32'h0);
        add("b2b lw A",     0, W,  32'h40, 32'h0,         0, 32'h0102_0304);
        add("b2b sw A2",    1, W,  32'h40, 32'hA5A5_A5A5, 0, 32'h0);
        add("b2b lw A2",    0, W,  32'h40, 32'h0,         0, 32'hA5A5_A5A5);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset valid", {31'b0, resp_valid}, 32'd0);
        check("reset fault", {31'b0, resp_fault}, 32'd0);
        check("reset rdata", resp_rdata, 32'd0);
        check("reset ready", {31'b0, req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("ready after reset", {31'b0, req_ready}, 32'd1);

        // Whole table issued back-to-back, one request per cycle
        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].f3, vecs[i].off, vecs[i].wd);
            @(posedge clk);
            @(negedge clk);
            check({vecs[i].name, " valid"}, {31'b0, resp_valid}, 32'd1);
            check({vecs[i].name, " fault"}, {31'b0, resp_fault}, {31'b0, vecs[i].fault});
            check({vecs[i].name, " rdata"}, resp_rdata, vecs[i].rd);
        end
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle valid", {31'b0, resp_valid}, 32'd0);

        // Reset in the cycle after an accepted store: response visible, then cleared
        drive(1'b1, W, 32'h30, 32'h7777_7777);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst-after ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst-after valid", {31'b0, resp_valid}, 32'd0);
        check("rst-after rdata", resp_rdata, 32'd0);

        // Reset coincident with a store: dropped, no response, no write
        drive(1'b1, W, 32'h30, 32'h9999_9999);
        @(posedge clk);
        @(negedge clk);
        check("rst-coinc valid", {31'b0, resp_valid}, 32'd0);
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        single("lw after rst", 0, W, 32'h30, 32'h0, 0, 32'h7777_7777);
        single("mem retained", 0, W, 32'h10, 32'h0, 0, 32'h80AD_BEEF);
        single("b2b retained", 0, W, 32'h40, 32'h0, 0, 32'hA5A5_A5A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
